// File: rtl/mem_stage_wb_pkg.sv
// Shared encodings for the MEM-stage Wishbone load/store engine:
// RISC-V funct3 sizes, trap codes and the request FSM state type.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [3:0] TRAP_LD_MISALIGN = 4'd4;
  localparam logic [3:0] TRAP_LD_FAULT    = 4'd5;
  localparam logic [3:0] TRAP_ST_MISALIGN = 4'd6;
  localparam logic [3:0] TRAP_ST_FAULT    = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // funct3[1:0] is the access size for both signed and unsigned forms
  function automatic logic misaligned(input logic [2:0] funct3, input logic [2:0] addr_lo);
    case (funct3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return addr_lo[0];
      2'b10:   return |addr_lo[1:0];
      default: return |addr_lo;
    endcase
  endfunction

  function automatic logic [7:0] size_mask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 8'h01;
      2'b01:   return 8'h03;
      2'b10:   return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load aligner: shifts the bus word down by the byte-lane
// offset and sign/zero-extends to XLEN according to funct3.
module mem_load_align
  import mem_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int OFFW = $clog2(XLEN / 8)
) (
  input  logic [2:0]      funct3_i,
  input  logic [OFFW-1:0] offset_i,
  input  logic [XLEN-1:0] raw_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] shifted;

  assign shifted = raw_i >> {offset_i, 3'b000};

  always_comb begin
    data_o = shifted;
    case (funct3_i)
      F3_B:    data_o = XLEN'($signed(shifted[7:0]));
      F3_H:    data_o = XLEN'($signed(shifted[15:0]));
      F3_W:    data_o = XLEN'($signed(shifted[31:0]));
      F3_BU:   data_o = XLEN'(shifted[7:0]);
      F3_HU:   data_o = XLEN'(shifted[15:0]);
      F3_WU:   data_o = XLEN'(shifted[31:0]);
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_wb.sv
// MEM-stage load/store engine driving a Wishbone-B4 classic master port,
// with bus timeout, flush draining and synchronous trap reporting.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a request; early traps skip the bus entirely
// ST_BUS   | cyc/stb asserted, waiting for ack/err/timeout
// ST_DONE  | one-cycle completion pulse with data or trap
// ST_DRAIN | flushed mid-cycle; finish the bus cycle silently
module mem_stage_wb
  import mem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [XLEN-1:0]   req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [XLEN-1:0]   rdata_o,
  output logic              trap_o,
  output logic [3:0]        trap_code_o,
  output logic [XLEN-1:0]   wbm_addr_o,
  output logic [XLEN-1:0]   wbm_dat_o,
  output logic [XLEN/8-1:0] wbm_sel_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  input  logic [XLEN-1:0]   wbm_dat_i,
  input  logic              wbm_ack_i,
  input  logic              wbm_err_i
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CNTW = $clog2(TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q;
  logic [2:0]      funct3_q;
  logic [OFFW-1:0] off_q;
  logic            bus_q, we_q, trap_q;
  logic [NB-1:0]   sel_q, sel_d;
  logic [XLEN-1:0] addr_q, dat_q, rdata_q, dat_d, load_data;
  logic [3:0]      code_q, early_code;
  logic            accept, illegal, misalign, timeout, bus_end, bus_fault;

  assign accept   = (state_q == ST_IDLE) & req_valid_i & ~flush_i;
  assign illegal  = (req_funct3_i == 3'b111) |
                    ((XLEN == 32) & ((req_funct3_i == F3_D) | (req_funct3_i == F3_WU)));
  assign misalign = misaligned(req_funct3_i, req_addr_i[2:0]);
  assign early_code = req_we_i ? (illegal ? TRAP_ST_FAULT : TRAP_ST_MISALIGN)
                               : (illegal ? TRAP_LD_FAULT : TRAP_LD_MISALIGN);

  // ack beats a coincident timeout, err beats ack
  assign timeout   = (cnt_q == CNTW'(TIMEOUT - 1));
  assign bus_end   = wbm_ack_i | wbm_err_i | timeout;
  assign bus_fault = wbm_err_i | (timeout & ~wbm_ack_i);

  assign sel_d = NB'(size_mask(req_funct3_i)) << req_addr_i[OFFW-1:0];

  always_comb begin
    dat_d = req_wdata_i;
    case (req_funct3_i[1:0])
      2'b00:   dat_d = {NB{req_wdata_i[7:0]}};
      2'b01:   dat_d = {(XLEN/16){req_wdata_i[15:0]}};
      2'b10:   dat_d = {(XLEN/32){req_wdata_i[31:0]}};
      default: dat_d = req_wdata_i;
    endcase
  end

  mem_load_align #(.XLEN(XLEN)) u_align (
    .funct3_i (funct3_q),
    .offset_i (off_q),
    .raw_i    (wbm_dat_i),
    .data_o   (load_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = (illegal | misalign) ? ST_DONE : ST_BUS;
      end
      ST_BUS: begin
        if (bus_end)      state_d = flush_i ? ST_IDLE : ST_DONE;
        else if (flush_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (bus_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stall_o = req_valid_i & (state_q != ST_DONE);
    done_o  = (state_q == ST_DONE);
  end

  // Result registers are only non-zero during the DONE cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      funct3_q <= '0;
      off_q    <= '0;
      bus_q    <= 1'b0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      addr_q   <= '0;
      dat_q    <= '0;
      rdata_q  <= '0;
      trap_q   <= 1'b0;
      code_q   <= '0;
    end else begin
      trap_q  <= 1'b0;
      code_q  <= '0;
      rdata_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (illegal | misalign) begin
              trap_q <= 1'b1;
              code_q <= early_code;
            end else begin
              bus_q    <= 1'b1;
              we_q     <= req_we_i;
              sel_q    <= sel_d;
              addr_q   <= {req_addr_i[XLEN-1:OFFW], {OFFW{1'b0}}};
              dat_q    <= dat_d;
              funct3_q <= req_funct3_i;
              off_q    <= req_addr_i[OFFW-1:0];
              cnt_q    <= '0;
            end
          end
        end
        ST_BUS: begin
          cnt_q <= cnt_q + 1'b1;
          if (bus_end) begin
            bus_q <= 1'b0;
            if (!flush_i) begin
              if (bus_fault) begin
                trap_q <= 1'b1;
                code_q <= we_q ? TRAP_ST_FAULT : TRAP_LD_FAULT;
              end else if (!we_q) begin
                rdata_q <= load_data;
              end
            end
          end
        end
        ST_DRAIN: begin
          cnt_q <= cnt_q + 1'b1;
          if (bus_end) bus_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign wbm_cyc_o   = bus_q;
  assign wbm_stb_o   = bus_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_addr_o  = addr_q;
  assign wbm_dat_o   = dat_q;
  assign rdata_o     = rdata_q;
  assign trap_o      = trap_q;
  assign trap_code_o = code_q;

endmodule

// File: tb/tb_mem_stage_wb.sv
// Bench for mem_stage_wb: a 32-bit instance (TIMEOUT=4) driven from a vector
// table with a scoreboard, and a 64-bit instance (TIMEOUT=8) for wide lanes.
module tb_mem_stage_wb;
  import mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc_cnt = 0;
  int   n_cmp = 0, n_bad = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // 32-bit DUT
  logic        a_valid = 0, a_we = 0, a_flush = 0;
  logic [2:0]  a_f3 = 0;
  logic [31:0] a_addr = 0, a_wdata = 0, a_din = 0;
  logic        a_ack = 0, a_err = 0;
  logic        a_stall, a_done, a_trap, a_cyc, a_stb, a_wbwe;
  logic [31:0] a_rdata, a_wbaddr, a_wbdat;
  logic [3:0]  a_code, a_sel;

  mem_stage_wb #(.XLEN(32), .TIMEOUT(4)) u_a (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(a_valid), .req_we_i(a_we), .req_funct3_i(a_f3),
    .req_addr_i(a_addr), .req_wdata_i(a_wdata), .flush_i(a_flush),
    .stall_o(a_stall), .done_o(a_done), .rdata_o(a_rdata),
    .trap_o(a_trap), .trap_code_o(a_code),
    .wbm_addr_o(a_wbaddr), .wbm_dat_o(a_wbdat), .wbm_sel_o(a_sel),
    .wbm_cyc_o(a_cyc), .wbm_stb_o(a_stb), .wbm_we_o(a_wbwe),
    .wbm_dat_i(a_din), .wbm_ack_i(a_ack), .wbm_err_i(a_err)
  );

  // 64-bit DUT
  logic        b_valid = 0, b_we = 0, b_flush = 0;
  logic [2:0]  b_f3 = 0;
  logic [63:0] b_addr = 0, b_wdata = 0, b_din = 0;
  logic        b_ack = 0, b_err = 0;
  logic        b_stall, b_done, b_trap, b_cyc, b_stb, b_wbwe;
  logic [63:0] b_rdata, b_wbaddr, b_wbdat;
  logic [3:0]  b_code;
  logic [7:0]  b_sel;

  mem_stage_wb #(.XLEN(64), .TIMEOUT(8)) u_b (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(b_valid), .req_we_i(b_we), .req_funct3_i(b_f3),
    .req_addr_i(b_addr), .req_wdata_i(b_wdata), .flush_i(b_flush),
    .stall_o(b_stall), .done_o(b_done), .rdata_o(b_rdata),
    .trap_o(b_trap), .trap_code_o(b_code),
    .wbm_addr_o(b_wbaddr), .wbm_dat_o(b_wbdat), .wbm_sel_o(b_sel),
    .wbm_cyc_o(b_cyc), .wbm_stb_o(b_stb), .wbm_we_o(b_wbwe),
    .wbm_dat_i(b_din), .wbm_ack_i(b_ack), .wbm_err_i(b_err)
  );

  // Slaves: respond in the dly-th cycle of stb; kind bit0 = ack, bit1 = err, 0 = never.
  logic [1:0]  a_kind = 0, b_kind = 0;
  int          a_dly = 0, b_dly = 0, a_scnt = 0, b_scnt = 0;
  logic [31:0] a_data = 0;
  logic [63:0] b_data = 0;

  always @(negedge clk) begin
    if (a_cyc && a_stb) begin
      a_scnt++;
      if (a_kind != 2'd0 && a_scnt == a_dly) begin
        a_ack = a_kind[0]; a_err = a_kind[1]; a_din = a_data;
      end else begin
        a_ack = 1'b0; a_err = 1'b0;
      end
    end else begin
      a_scnt = 0; a_ack = 1'b0; a_err = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (b_cyc && b_stb) begin
      b_scnt++;
      if (b_kind != 2'd0 && b_scnt == b_dly) begin
        b_ack = b_kind[0]; b_err = b_kind[1]; b_din = b_data;
      end else begin
        b_ack = 1'b0; b_err = 1'b0;
      end
    end else begin
      b_scnt = 0; b_ack = 1'b0; b_err = 1'b0;
    end
  end

  // Scoreboard for the 32-bit DUT
  typedef struct {
    logic [31:0] rdata;
    logic        trap;
    logic [3:0]  code;
    int          due;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    exp_t e;
    if (a_done) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_done: done_o=1 at cycle %0d, expected 0", cyc_cnt);
      end else begin
        e = sb.pop_front();
        check("sb_rdata", a_rdata, e.rdata);
        check("sb_trap", a_trap, e.trap);
        check("sb_code", a_code, e.code);
        check("sb_done_cycle", cyc_cnt, e.due);
      end
    end
  end

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic        we;
    logic [31:0] addr, wdata, bus;
    logic [1:0]  kind;
    int          dly;
    logic        cyc;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        trap;
    logic [3:0]  code;
    logic [31:0] rdata;
    int          lat;
  } vec_t;
  vec_t vt[$];

  task automatic add(input string nm, input logic [2:0] f3, input logic we,
                     input logic [31:0] addr, wdata, bus, input logic [1:0] kind, input int dly,
                     input logic cyc, input logic [3:0] sel, input logic [31:0] dat,
                     input logic trap, input logic [3:0] code, input logic [31:0] rdata, input int lat);
    vec_t v;
    v.name = nm; v.f3 = f3; v.we = we; v.addr = addr; v.wdata = wdata; v.bus = bus;
    v.kind = kind; v.dly = dly; v.cyc = cyc; v.sel = sel; v.dat = dat;
    v.trap = trap; v.code = code; v.rdata = rdata; v.lat = lat;
    vt.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    bit   seen;
    @(negedge clk);
    a_kind = v.kind; a_dly = v.dly; a_data = v.bus;
    a_f3 = v.f3; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata; a_valid = 1'b1;
    #1;
    check({v.name, "/stall_accept"}, a_stall, 1'b1);
    e.rdata = v.rdata; e.trap = v.trap; e.code = v.code; e.due = cyc_cnt + v.lat;
    sb.push_back(e);
    @(negedge clk);
    check({v.name, "/cyc"}, a_cyc, v.cyc);
    if (v.cyc) begin
      check({v.name, "/stb"}, a_stb, 1'b1);
      check({v.name, "/sel"}, a_sel, v.sel);
      check({v.name, "/dat"}, a_wbdat, v.dat);
      check({v.name, "/we"}, a_wbwe, v.we);
      check({v.name, "/addr"}, a_wbaddr, v.addr & ~32'h3);
    end
    seen = 0;
    for (int i = 0; i < 16 && !seen; i++) begin
      if (a_done) seen = 1;
      else @(negedge clk);
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL %s/done_wait: done_o=0 after 16 cycles, expected 1", v.name);
    end else begin
      check({v.name, "/stall_done"}, a_stall, 1'b0);
    end
    a_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_a_zero(input string tag);
    check({tag, "/cyc"}, a_cyc, 1'b0);
    check({tag, "/stb"}, a_stb, 1'b0);
    check({tag, "/we"}, a_wbwe, 1'b0);
    check({tag, "/sel"}, a_sel, 4'h0);
    check({tag, "/addr"}, a_wbaddr, 32'h0);
    check({tag, "/dat"}, a_wbdat, 32'h0);
    check({tag, "/done"}, a_done, 1'b0);
    check({tag, "/trap"}, a_trap, 1'b0);
    check({tag, "/rdata"}, a_rdata, 32'h0);
    check({tag, "/code"}, a_code, 4'h0);
  endtask

  task automatic run_b(input string nm, input logic [2:0] f3, input logic we,
                       input logic [63:0] addr, wdata, bus, input int dly,
                       input logic [7:0] sel, input logic [63:0] dat, rdata,
                       input logic trap, input logic [3:0] code, input int lat);
    int c;
    bit seen;
    @(negedge clk);
    b_kind = (dly == 0) ? 2'd0 : 2'd1; b_dly = dly; b_data = bus;
    b_f3 = f3; b_we = we; b_addr = addr; b_wdata = wdata; b_valid = 1'b1;
    c = cyc_cnt;
    @(negedge clk);
    if (sel != 8'h0) begin
      check({nm, "/cyc"}, b_cyc, 1'b1);
      check({nm, "/sel"}, b_sel, sel);
      check({nm, "/dat"}, b_wbdat, dat);
      check({nm, "/we"}, b_wbwe, we);
      check({nm, "/addr"}, b_wbaddr, addr & ~64'h7);
    end else begin
      check({nm, "/cyc"}, b_cyc, 1'b0);
    end
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (b_done) seen = 1;
      else @(negedge clk);
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL %s/done_wait: done_o=0 after 20 cycles, expected 1", nm);
    end else begin
      check({nm, "/done_cycle"}, cyc_cnt, c + lat);
      check({nm, "/rdata"}, b_rdata, rdata);
      check({nm, "/trap"}, b_trap, trap);
      check({nm, "/code"}, b_code, code);
    end
    b_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    add("lw",        F3_W,  0, 32'h100, 32'h0, 32'hDEADBEEF, 2'd1, 1, 1, 4'hF, 32'h0, 0, 4'd0, 32'hDEADBEEF, 2);
    add("lb_neg",    F3_B,  0, 32'h103, 32'h0, 32'h80FFFFFF, 2'd1, 1, 1, 4'h8, 32'h0, 0, 4'd0, 32'hFFFFFF80, 2);
    add("lbu",       F3_BU, 0, 32'h103, 32'h0, 32'h80FFFFFF, 2'd1, 1, 1, 4'h8, 32'h0, 0, 4'd0, 32'h00000080, 2);
    add("lb_pos",    F3_B,  0, 32'h100, 32'h0, 32'h1234567F, 2'd1, 1, 1, 4'h1, 32'h0, 0, 4'd0, 32'h0000007F, 2);
    add("lh_hi",     F3_H,  0, 32'h102, 32'h0, 32'h80011234, 2'd1, 2, 1, 4'hC, 32'h0, 0, 4'd0, 32'hFFFF8001, 3);
    add("lhu_hi",    F3_HU, 0, 32'h102, 32'h0, 32'h80011234, 2'd1, 1, 1, 4'hC, 32'h0, 0, 4'd0, 32'h00008001, 2);
    add("lh_lo",     F3_H,  0, 32'h100, 32'h0, 32'h80011234, 2'd1, 1, 1, 4'h3, 32'h0, 0, 4'd0, 32'h00001234, 2);
    add("lbu_late",  F3_BU, 0, 32'h102, 32'h0, 32'h00AB0000, 2'd1, 3, 1, 4'h4, 32'h0, 0, 4'd0, 32'h000000AB, 4);
    add("sb",        F3_B,  1, 32'h101, 32'h000000A5, 32'h0, 2'd1, 2, 1, 4'h2, 32'hA5A5A5A5, 0, 4'd0, 32'h0, 3);
    add("sh",        F3_H,  1, 32'h100, 32'hCAFEBEEF, 32'h0, 2'd1, 1, 1, 4'h3, 32'hBEEFBEEF, 0, 4'd0, 32'h0, 2);
    add("sw",        F3_W,  1, 32'h204, 32'h11223344, 32'h0, 2'd1, 3, 1, 4'hF, 32'h11223344, 0, 4'd0, 32'h0, 4);
    add("sw_mis",    F3_W,  1, 32'h102, 32'h55, 32'h0, 2'd1, 1, 0, 4'h0, 32'h0, 1, 4'd6, 32'h0, 1);
    add("lw_mis",    F3_W,  0, 32'h101, 32'h0, 32'h0, 2'd1, 1, 0, 4'h0, 32'h0, 1, 4'd4, 32'h0, 1);
    add("lh_mis",    F3_H,  0, 32'h103, 32'h0, 32'h0, 2'd1, 1, 0, 4'h0, 32'h0, 1, 4'd4, 32'h0, 1);
    add("sh_mis",    F3_H,  1, 32'h105, 32'h0, 32'h0, 2'd1, 1, 0, 4'h0, 32'h0, 1, 4'd6, 32'h0, 1);
    add("ld_ill",    F3_D,  0, 32'h100, 32'h0, 32'h0, 2'd1, 1, 0, 4'h0, 32'h0, 1, 4'd5, 32'h0, 1);
    add("lwu_ill",   F3_WU, 0, 32'h100, 32'h0, 32'h0, 2'd1, 1, 0, 4'h0, 32'h0, 1, 4'd5, 32'h0, 1);
    add("sd_ill",    F3_D,  1, 32'h108, 32'h0, 32'h0, 2'd1, 1, 0, 4'h0, 32'h0, 1, 4'd7, 32'h0, 1);
    add("lw_tmo",    F3_W,  0, 32'h200, 32'h0, 32'h0, 2'd0, 0, 1, 4'hF, 32'h0, 1, 4'd5, 32'h0, 5);
    add("sw_tmo",    F3_W,  1, 32'h300, 32'h1, 32'h0, 2'd0, 0, 1, 4'hF, 32'h1, 1, 4'd7, 32'h0, 5);
    add("sw_err",    F3_W,  1, 32'h204, 32'h99, 32'h0, 2'd2, 2, 1, 4'hF, 32'h99, 1, 4'd7, 32'h0, 3);
    add("lw_ackerr", F3_W,  0, 32'h208, 32'h0, 32'h1111, 2'd3, 1, 1, 4'hF, 32'h0, 1, 4'd5, 32'h0, 2);

    repeat (2) @(negedge clk);
    chk_a_zero("reset");
    check("reset/b_bus", {b_cyc, b_stb, b_wbwe, b_done, b_trap}, 5'b0);
    check("reset/b_data", b_wbaddr | b_wbdat | b_rdata | {56'h0, b_sel} | {60'h0, b_code}, 64'h0);
    check("reset/stall_idle", a_stall, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) run_vec(vt[i]);

    // Flush in BUS: cycle must drain on the late ack with no completion.
    @(negedge clk);
    a_kind = 2'd1; a_dly = 3; a_data = 32'h0BAD0BAD;
    a_f3 = F3_W; a_we = 1'b0; a_addr = 32'h300; a_valid = 1'b1;
    @(negedge clk);
    check("flush/cyc_bus", a_cyc, 1'b1);
    a_flush = 1'b1; a_valid = 1'b0;
    @(negedge clk);
    a_flush = 1'b0;
    check("flush/cyc_drain1", a_cyc, 1'b1);
    check("flush/stb_drain1", a_stb, 1'b1);
    @(negedge clk);
    check("flush/cyc_drain2", a_cyc, 1'b1);
    @(negedge clk);
    check("flush/cyc_released", a_cyc, 1'b0);
    check("flush/no_done", a_done, 1'b0);
    run_vec(vt[0]);

    // Reset in the middle of a bus cycle.
    @(negedge clk);
    a_kind = 2'd0; a_f3 = F3_W; a_we = 1'b1; a_addr = 32'h400; a_wdata = 32'h5555AAAA; a_valid = 1'b1;
    @(negedge clk);
    check("midrst/cyc_before", a_cyc, 1'b1);
    @(negedge clk);
    rst = 1'b1; a_valid = 1'b0;
    @(negedge clk);
    chk_a_zero("midrst");
    rst = 1'b0;
    @(negedge clk);
    check("midrst/no_done", a_done, 1'b0);
    run_vec(vt[1]);

    run_b("b_sh",   F3_H,  1, 64'h6, 64'h1234, 64'h0, 1, 8'hC0, 64'h1234123412341234, 64'h0, 0, 4'd0, 2);
    run_b("b_lw",   F3_W,  0, 64'h4, 64'h0, 64'h80000000_00000000, 1, 8'hF0, 64'h0, 64'hFFFFFFFF_80000000, 0, 4'd0, 2);
    run_b("b_lwu",  F3_WU, 0, 64'h4, 64'h0, 64'h80000000_00000000, 1, 8'hF0, 64'h0, 64'h00000000_80000000, 0, 4'd0, 2);
    run_b("b_ld",   F3_D,  0, 64'h8, 64'h0, 64'h01234567_89ABCDEF, 2, 8'hFF, 64'h0, 64'h01234567_89ABCDEF, 0, 4'd0, 3);
    run_b("b_lb",   F3_B,  0, 64'h5, 64'h0, 64'h00009100_00000000, 1, 8'h20, 64'h0, 64'hFFFFFFFF_FFFFFF91, 0, 4'd0, 2);
    run_b("b_sb",   F3_B,  1, 64'h7, 64'h5A, 64'h0, 1, 8'h80, 64'h5A5A5A5A_5A5A5A5A, 64'h0, 0, 4'd0, 2);
    run_b("b_sw",   F3_W,  1, 64'hC, 64'hAABBCCDD, 64'h0, 1, 8'hF0, 64'hAABBCCDD_AABBCCDD, 64'h0, 0, 4'd0, 2);
    run_b("b_ldmis", F3_D, 0, 64'h4, 64'h0, 64'h0, 1, 8'h00, 64'h0, 64'h0, 1, 4'd4, 1);
    run_b("b_tmo",  F3_W,  0, 64'h10, 64'h0, 64'h0, 0, 8'h0F, 64'h0, 64'h0, 1, 4'd5, 9);

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
